rv32i_core: RTL and testbench
=============================

Name: rv32i_core

Overview:
- Single-cycle RV32I integer core: fetch, decode, execute, memory access and writeback all complete in one clock.
- Contains a 32x32 register file, a 1024-word instruction memory and a 1024-word data memory.
- Top-level processor block. Its only ports are clock and reset.
- Benches preload memories and registers through fixed hierarchical names.

Parameters:
- XLEN, 32, datapath width (fixed at 32).
- IMEM_WORDS, 1024, instruction memory depth in words.
- DMEM_WORDS, 1024, data memory depth in words.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Hierarchical names are fixed and relied on by benches:
  - pc: current PC.
  - pc_in: next PC.
  - instruction_mux_out: instruction being executed.
  - mux_a_out, mux_b_out: ALU operands.
  - alu_out: ALU result.
  - register_file.regFile[0:31]: register array.
  - insn_memory.mem[0:1023], data_memory.mem[0:1023]: memory arrays.
- Reset:
  - When reset=1 at a clk rising edge, pc <= RESET_PC.
  - Register file and both memories are NOT cleared, so preloaded contents persist.
  - While reset=1, instruction_mux_out = 32'h00000013 (NOP) and no register or memory write occurs.
- Fetch: instruction_mux_out = insn_memory.mem[pc[11:2]] (combinational). pc[1:0] are ignored.
- Register file:
  - Two combinational read ports, one write port updated on the rising edge.
  - Reading x0 returns 0. Writes to x0 are discarded.
- Supported instructions (opcode / funct per RV32I):
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Immediates: I/S/B/U/J formats, sign-extended per the ISA.
- ALU operands:
  - mux_a_out = rs1, or pc for AUIPC/JAL/branch target.
  - mux_b_out = rs2 or immediate.
- ALU arithmetic:
  - ADD/SUB modulo 2^32.
  - SLT/SLTI: signed compare, result 1 or 0.
  - SLTU/SLTIU: unsigned compare, result 1 or 0.
  - Shift amount = operand_b[4:0]. SRA/SRAI are arithmetic (sign-filling).
- Next PC (pc_in):
  - Default pc+4.
  - Taken branch: pc+immB.
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
  - JAL and JALR write pc+4 to rd.
- Memory:
  - LW: rd <= data_memory.mem[alu_out[11:2]] (combinational read).
  - SW: writes rs2 to data_memory.mem[alu_out[11:2]] on the rising edge.
  - Addresses wrap modulo 4 KB.
  - Load/store widths other than word (LB/LH/LBU/LHU/SB/SH) execute as LW/SW.
- Unsupported opcode or funct: executes as NOP (no writes, pc+4).
- Latency: each instruction retires on the rising edge ending its cycle. CPI = 1.

Optional Feature:
- Macro RV32I_CORE_MUL_EN.
- When defined: opcode OP with funct7=0000001 and funct3=000 executes MUL, rd <= low 32 bits of rs1*rs2.
- Other funct3 values with funct7=0000001 execute as NOP.
- When undefined: all funct7=0000001 OP encodings execute as NOP.

Test Plan:
- Reset: reset=1 for one edge with pc=0x40 → pc=0.
  - regFile[5] preloaded 5 remains 5.
  - No memory write while reset is high.
- SLT signed:
  - regFile[k]=k; program ADDI x1,x1,-2 (0xFFE08093); ADDI x2,x2,-3 (0xFFD10113); SLT x3,x1,x2 (0x0020A1B3).
  - After 3 cycles: x1=0xFFFFFFFF, x2=0xFFFFFFFF, x3=0.
  - Repeat with the second immediate changed to -4: x2=0xFFFFFFFE, x3=0.
  - Swapped operands (SLT x3,x2,x1): x3=1.
- SLTU vs SLT:
  - x1=0xFFFFFFFF, x2=1.
  - SLTU x3,x1,x2 → x3=0.
  - SLT x3,x1,x2 → x3=1.
- Load/store:
  - SW x2,8(x0) with x2=0x1234 → data_memory.mem[2]=0x1234.
  - Following LW x4,8(x0) → x4=0x1234.
- Control flow:
  - BEQ x0,x0,+8 at pc=0 → pc=8.
  - JAL x1,+16 at pc=8 → x1=12, pc=24.
  - JALR x0,0(x1) → pc=12.
- x0 write and MUL:
  - ADDI x0,x0,5 → x0 reads 0.
  - With RV32I_CORE_MUL_EN: MUL x3,x1,x2 with x1=7, x2=6 → x3=42.
  - Without RV32I_CORE_MUL_EN: x3 unchanged, pc+4.

Source files
------------

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with register file and word memories.
// Define RV32I_CORE_MUL_EN to add the MUL instruction (OP, funct7=0000001).
module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] regFile [0:31];

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regFile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regFile[rs2_addr];

  always_ff @(posedge clk) begin
    if (we && rd_addr != 5'd0) begin
      regFile[rd_addr] <= rd_data;
    end
  end
endmodule

module rv32i_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end
endmodule

module rv32i_core #(
  parameter int                XLEN       = 32,
  parameter int                IMEM_WORDS = 1024,
  parameter int                DMEM_WORDS = 1024,
  parameter logic [XLEN-1:0]   RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
`ifdef RV32I_CORE_MUL_EN
  localparam logic [3:0] ALU_MUL   = 4'd11;
`endif

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_plus4;
  logic [31:0]     insn_word;
  logic [31:0]     instruction_mux_out;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] mux_a_out;
  logic [XLEN-1:0] mux_b_out;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm;

  logic       op_lui;
  logic       op_auipc;
  logic       op_jal;
  logic       op_jalr;
  logic       op_branch;
  logic       op_load;
  logic       op_store;
  logic       op_opimm;
  logic       op_op;

  logic [3:0] alu_op;
  logic       a_sel_pc;
  logic       b_sel_imm;
  logic       reg_we;
  logic       mem_we;
  logic [1:0] wb_sel;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;
  logic       br_taken;

  // Fetch; reset forces a NOP so nothing retires while held.
  rv32i_mem #(
    .WORDS (IMEM_WORDS),
    .AW    (IMEM_AW)
  ) insn_memory (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IMEM_AW+1:2]),
    .wdata (32'd0),
    .rdata (insn_word)
  );

  assign instruction_mux_out = reset ? NOP : insn_word;

  assign opcode = instruction_mux_out[6:0];
  assign rd     = instruction_mux_out[11:7];
  assign funct3 = instruction_mux_out[14:12];
  assign rs1    = instruction_mux_out[19:15];
  assign rs2    = instruction_mux_out[24:20];
  assign funct7 = instruction_mux_out[31:25];

  assign imm_i = {{20{instruction_mux_out[31]}},
                  instruction_mux_out[31:20]};
  assign imm_s = {{20{instruction_mux_out[31]}},
                  instruction_mux_out[31:25],
                  instruction_mux_out[11:7]};
  assign imm_b = {{19{instruction_mux_out[31]}},
                  instruction_mux_out[31],
                  instruction_mux_out[7],
                  instruction_mux_out[30:25],
                  instruction_mux_out[11:8],
                  1'b0};
  assign imm_u = {instruction_mux_out[31:12], 12'd0};
  assign imm_j = {{11{instruction_mux_out[31]}},
                  instruction_mux_out[31],
                  instruction_mux_out[19:12],
                  instruction_mux_out[20],
                  instruction_mux_out[30:21],
                  1'b0};

  assign op_lui    = (opcode == 7'b0110111);
  assign op_auipc  = (opcode == 7'b0010111);
  assign op_jal    = (opcode == 7'b1101111);
  assign op_jalr   = (opcode == 7'b1100111);
  assign op_branch = (opcode == 7'b1100011);
  assign op_load   = (opcode == 7'b0000011);
  assign op_store  = (opcode == 7'b0100011);
  assign op_opimm  = (opcode == 7'b0010011);
  assign op_op     = (opcode == 7'b0110011);

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    alu_op    = ALU_ADD;
    a_sel_pc  = 1'b0;
    b_sel_imm = 1'b0;
    imm       = imm_i;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    wb_sel    = WB_ALU;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    unique case (1'b1)
      op_lui: begin
        alu_op    = ALU_PASSB;
        b_sel_imm = 1'b1;
        imm       = imm_u;
        reg_we    = 1'b1;
      end
      op_auipc: begin
        a_sel_pc  = 1'b1;
        b_sel_imm = 1'b1;
        imm       = imm_u;
        reg_we    = 1'b1;
      end
      op_jal: begin
        a_sel_pc  = 1'b1;
        b_sel_imm = 1'b1;
        imm       = imm_j;
        reg_we    = 1'b1;
        wb_sel    = WB_PC4;
        is_jal    = 1'b1;
      end
      op_jalr: begin
        if (funct3 == 3'b000) begin
          b_sel_imm = 1'b1;
          reg_we    = 1'b1;
          wb_sel    = WB_PC4;
          is_jalr   = 1'b1;
        end
      end
      op_branch: begin
        a_sel_pc  = 1'b1;
        b_sel_imm = 1'b1;
        imm       = imm_b;
        is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      // Narrow loads/stores are treated as full words.
      op_load: begin
        b_sel_imm = 1'b1;
        reg_we    = 1'b1;
        wb_sel    = WB_MEM;
      end
      op_store: begin
        b_sel_imm = 1'b1;
        imm       = imm_s;
        mem_we    = 1'b1;
      end
      op_opimm: begin
        b_sel_imm = 1'b1;
        alu_op    = base_op(funct3);
        reg_we    = 1'b1;
        if (funct3 == 3'b001) begin
          reg_we = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) begin
            alu_op = ALU_SRA;
          end else if (funct7 != 7'b0000000) begin
            reg_we = 1'b0;
          end
        end
      end
      op_op: begin
        if (funct7 == 7'b0000000) begin
          alu_op = base_op(funct3);
          reg_we = 1'b1;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            alu_op = ALU_SUB;
            reg_we = 1'b1;
          end else if (funct3 == 3'b101) begin
            alu_op = ALU_SRA;
            reg_we = 1'b1;
          end
        end
`ifdef RV32I_CORE_MUL_EN
        else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          alu_op = ALU_MUL;
          reg_we = 1'b1;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  rv32i_regfile register_file (
    .clk      (clk),
    .we       (reg_we && !reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .rd_data  (wb_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  assign mux_a_out = a_sel_pc ? pc : rs1_data;
  assign mux_b_out = b_sel_imm ? imm : rs2_data;

  always_comb begin
    unique case (alu_op)
      ALU_ADD:   alu_out = mux_a_out + mux_b_out;
      ALU_SUB:   alu_out = mux_a_out - mux_b_out;
      ALU_SLL:   alu_out = mux_a_out << mux_b_out[4:0];
      ALU_SLT:   alu_out = {31'd0, $signed(mux_a_out) < $signed(mux_b_out)};
      ALU_SLTU:  alu_out = {31'd0, mux_a_out < mux_b_out};
      ALU_XOR:   alu_out = mux_a_out ^ mux_b_out;
      ALU_SRL:   alu_out = mux_a_out >> mux_b_out[4:0];
      ALU_SRA:   alu_out = $signed(mux_a_out) >>> mux_b_out[4:0];
      ALU_OR:    alu_out = mux_a_out | mux_b_out;
      ALU_AND:   alu_out = mux_a_out & mux_b_out;
      ALU_PASSB: alu_out = mux_b_out;
`ifdef RV32I_CORE_MUL_EN
      ALU_MUL:   alu_out = mux_a_out * mux_b_out;
`endif
      default:   alu_out = mux_a_out + mux_b_out;
    endcase
  end

  // Branch compare runs beside the ALU, which is busy forming the target.
  always_comb begin
    br_taken = 1'b0;
    unique case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  br_taken = !($signed(rs1_data) < $signed(rs2_data));
      3'b110:  br_taken = (rs1_data < rs2_data);
      3'b111:  br_taken = !(rs1_data < rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  rv32i_mem #(
    .WORDS (DMEM_WORDS),
    .AW    (DMEM_AW)
  ) data_memory (
    .clk   (clk),
    .we    (mem_we && !reset),
    .addr  (alu_out[DMEM_AW+1:2]),
    .wdata (rs2_data),
    .rdata (load_data)
  );

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    unique case (wb_sel)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_out;
    endcase
  end

  always_comb begin
    if (is_jalr) begin
      pc_in = {alu_out[XLEN-1:1], 1'b0};
    end else if (is_jal || (is_branch && br_taken)) begin
      pc_in = alu_out;
    end else begin
      pc_in = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_in;
    end
  end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs with hand-computed results.
// Build with +define+RV32I_CORE_MUL_EN to expect MUL to execute.
module tb_rv32i_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] JALR  = 7'b1100111;

  rv32i_core dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] im, input logic [4:0] rd, input logic [6:0] op);
    return {im, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic set_insn(input int idx, input logic [31:0] v);
    dut.insn_memory.mem[idx] <= v;
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    dut.register_file.regFile[idx] <= v;
  endtask

  task automatic set_dmem(input int idx, input logic [31:0] v);
    dut.data_memory.mem[idx] <= v;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // NOP-filled program, regFile[k]=k, pc back to 0.
  task automatic prep();
    for (int i = 0; i < 1024; i++) set_insn(i, 32'h0000_0013);
    for (int i = 0; i < 32; i++) set_reg(i, i);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    // Reset from pc=0x40 with a store sitting under the pc.
    prep();
    check("pc_after_reset", dut.pc, 32'h0);
    set_insn(16, enc_s(12'd8, 5'd2, 5'd0, 3'b010));
    set_reg(2, 32'h1234);
    set_dmem(2, 32'hDEAD);
    step(16);
    check("pc_before_reset", dut.pc, 32'h40);
    reset = 1'b1;
    #1;
    check("reset_nop", dut.instruction_mux_out, 32'h13);
    step(1);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_x5", dut.register_file.regFile[5], 32'd5);
    check("reset_nowrite", dut.data_memory.mem[2], 32'hDEAD);
    reset = 1'b0;

    // SLT signed, equal operands
    prep();
    set_insn(0, 32'hFFE08093);
    set_insn(1, 32'hFFD10113);
    set_insn(2, 32'h0020A1B3);
    step(3);
    check("slt1_x1", dut.register_file.regFile[1], 32'hFFFFFFFF);
    check("slt1_x2", dut.register_file.regFile[2], 32'hFFFFFFFF);
    check("slt1_x3", dut.register_file.regFile[3], 32'd0);

    // SLT signed, -1 vs -2 both ways
    prep();
    set_insn(0, 32'hFFE08093);
    set_insn(1, 32'hFFC10113);
    set_insn(2, 32'h0020A1B3);
    set_insn(3, 32'h001121B3);
    step(3);
    check("slt2_x2", dut.register_file.regFile[2], 32'hFFFFFFFE);
    check("slt2_x3", dut.register_file.regFile[3], 32'd0);
    step(1);
    check("slt2_swap_x3", dut.register_file.regFile[3], 32'd1);

    // SLTU vs SLT
    prep();
    set_reg(1, 32'hFFFFFFFF);
    set_reg(2, 32'd1);
    set_insn(0, 32'h0020B1B3);
    set_insn(1, 32'h0020A1B3);
    step(1);
    check("sltu_x3", dut.register_file.regFile[3], 32'd0);
    step(1);
    check("slt_x3", dut.register_file.regFile[3], 32'd1);

    // Assorted ALU ops and an unsupported opcode
    prep();
    set_insn(0, enc_u(20'h12345, 5'd5, 7'b0110111));
    set_insn(1, enc_u(20'h00001, 5'd6, 7'b0010111));
    set_insn(2, enc_u(20'h80000, 5'd7, 7'b0110111));
    set_insn(3, enc_i({7'b0100000, 5'd4}, 5'd7, 3'b101, 5'd8, OPIMM));
    set_insn(4, enc_i(12'h004, 5'd7, 3'b101, 5'd9, OPIMM));
    set_insn(5, enc_r(7'b0100000, 5'd7, 5'd4, 3'b000, 5'd10));
    set_insn(6, enc_r(7'b0000000, 5'd4, 5'd4, 3'b001, 5'd11));
    set_insn(7, enc_i(12'hFFF, 5'd7, 3'b100, 5'd12, OPIMM));
    set_insn(8, enc_i(12'h001, 5'd0, 3'b011, 5'd13, OPIMM));
    set_insn(9, enc_i(12'h000, 5'd7, 3'b010, 5'd14, OPIMM));
    set_insn(10, enc_r(7'b0000000, 5'd4, 5'd7, 3'b111, 5'd15));
    set_insn(11, enc_r(7'b0000000, 5'd4, 5'd7, 3'b110, 5'd16));
    set_insn(12, 32'hFFFFFFFF);
    set_insn(13, enc_r(7'b0100000, 5'd4, 5'd7, 3'b101, 5'd17));
    set_insn(14, enc_i(12'h0F0, 5'd4, 3'b110, 5'd18, OPIMM));
    step(15);
    check("lui", dut.register_file.regFile[5], 32'h12345000);
    check("auipc", dut.register_file.regFile[6], 32'h00001004);
    check("srai", dut.register_file.regFile[8], 32'hF8000000);
    check("srli", dut.register_file.regFile[9], 32'h08000000);
    check("sub", dut.register_file.regFile[10], 32'h80000004);
    check("sll", dut.register_file.regFile[11], 32'h40);
    check("xori", dut.register_file.regFile[12], 32'h7FFFFFFF);
    check("sltiu", dut.register_file.regFile[13], 32'd1);
    check("slti", dut.register_file.regFile[14], 32'd1);
    check("and", dut.register_file.regFile[15], 32'd0);
    check("or", dut.register_file.regFile[16], 32'h80000004);
    check("illegal_x31", dut.register_file.regFile[31], 32'd31);
    check("sra", dut.register_file.regFile[17], 32'hF8000000);
    check("ori", dut.register_file.regFile[18], 32'hF4);
    check("alu_pc", dut.pc, 32'd60);

    // Load/store, address wrap, narrow load as word
    prep();
    set_reg(2, 32'h1234);
    set_dmem(2, 32'h0);
    set_dmem(1023, 32'h0);
    set_insn(0, enc_s(12'd8, 5'd2, 5'd0, 3'b010));
    set_insn(1, enc_i(12'd8, 5'd0, 3'b010, 5'd4, LOAD));
    set_insn(2, enc_s(12'hFFC, 5'd2, 5'd0, 3'b010));
    set_insn(3, enc_i(12'd8, 5'd0, 3'b000, 5'd5, LOAD));
    step(1);
    check("sw_mem2", dut.data_memory.mem[2], 32'h1234);
    step(1);
    check("lw_x4", dut.register_file.regFile[4], 32'h1234);
    step(1);
    check("sw_wrap", dut.data_memory.mem[1023], 32'h1234);
    step(1);
    check("lb_as_lw", dut.register_file.regFile[5], 32'h1234);

    // Control flow: 0 -> 8 -> 24 -> 12 -> 16 -> 20 -> 0
    prep();
    set_reg(6, 32'h80000000);
    set_reg(7, 32'd4);
    set_insn(0, enc_b(13'd8, 5'd0, 5'd0, 3'b000));
    set_insn(2, enc_j(21'd16, 5'd1));
    set_insn(6, enc_i(12'd0, 5'd1, 3'b000, 5'd0, JALR));
    set_insn(3, enc_b(13'd100, 5'd0, 5'd0, 3'b001));
    set_insn(4, enc_b(13'd64, 5'd7, 5'd6, 3'b101));
    set_insn(5, enc_b(13'h1FEC, 5'd6, 5'd7, 3'b110));
    step(1);
    check("beq_pc", dut.pc, 32'd8);
    step(1);
    check("jal_pc", dut.pc, 32'd24);
    check("jal_x1", dut.register_file.regFile[1], 32'd12);
    step(1);
    check("jalr_pc", dut.pc, 32'd12);
    step(1);
    check("bne_nt_pc", dut.pc, 32'd16);
    step(1);
    check("bge_nt_pc", dut.pc, 32'd20);
    step(1);
    check("bltu_pc", dut.pc, 32'd0);

    // x0 and MUL
    prep();
    set_reg(0, 32'h55);
    set_reg(1, 32'd7);
    set_reg(2, 32'd6);
    set_insn(0, enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPIMM));
    set_insn(1, enc_i(12'd0, 5'd0, 3'b000, 5'd5, OPIMM));
    set_insn(2, enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3));
    set_insn(3, enc_r(7'b0000001, 5'd2, 5'd1, 3'b001, 5'd4));
    step(1);
    check("x0_nowrite", dut.register_file.regFile[0], 32'h55);
    step(1);
    check("x0_reads0", dut.register_file.regFile[5], 32'd0);
    step(1);
`ifdef RV32I_CORE_MUL_EN
    check("mul_x3", dut.register_file.regFile[3], 32'd42);
`else
    check("mul_nop_x3", dut.register_file.regFile[3], 32'd3);
`endif
    check("mul_pc", dut.pc, 32'd12);
    step(1);
    check("mulh_nop_x4", dut.register_file.regFile[4], 32'd4);
    check("mulh_pc", dut.pc, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
